// File: rtl/quadrature_encoder_emulator_if.sv
// ---------------------------------------------------------------------------
// quadrature_encoder_emulator_if
//
// Bundles the request strobes and quadrature/status outputs of the
// quadrature encoder emulator.
//
//   master modport (stimulus side): drives enable, stepCW, stepCCW;
//                                   observes encA, encB, busy, pending, overflow
//   slave modport  (emulator side): the reverse
//
// Parameter PENDING_W must match the emulator's PENDING_W.
// ---------------------------------------------------------------------------
interface quadrature_encoder_emulator_if #(
    parameter int PENDING_W = 4
);
    logic                        enable;
    logic                        stepCW;
    logic                        stepCCW;
    logic                        encA;
    logic                        encB;
    logic                        busy;
    logic signed [PENDING_W-1:0] pending;
    logic                        overflow;

    modport master (
        output enable, stepCW, stepCCW,
        input  encA, encB, busy, pending, overflow
    );

    modport slave (
        input  enable, stepCW, stepCCW,
        output encA, encB, busy, pending, overflow
    );
endinterface

// File: rtl/quadrature_encoder_emulator.sv
// ---------------------------------------------------------------------------
// quadrature_encoder_emulator
//
// Emulates a detented rotary encoder. CW/CCW request strobes are queued in a
// signed saturating pending counter; each queued step is played out as one
// full 4-phase Gray cycle on active-low channels encA/encB (idle high), each
// phase held DWELL_CYCLES clocks.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-high reset (outputs go idle immediately)
//   bus    - quadrature_encoder_emulator_if.slave:
//              enable   in  : accept requests and start steps
//              stepCW   in  : one-cycle strobe, queue one CW detent
//              stepCCW  in  : one-cycle strobe, queue one CCW detent
//              encA/encB out: quadrature channels, active-low, registered
//              busy     out : high while a step is playing
//              pending  out : signed queued steps (positive = CW)
//              overflow out : one-cycle pulse when a request is dropped
//
// Optional feature macro: QUAD_BOUNCE_EN
//   When defined, the channel that changes on entry to each phase bounces
//   BOUNCE_COUNT times (new level / old level, BOUNCE_CYCLES each) before
//   settling. When undefined, edges are clean and no bounce logic exists.
// ---------------------------------------------------------------------------
module quadrature_encoder_emulator #(
    parameter int DWELL_CYCLES  = 1000,
    parameter int PENDING_W     = 4,
    parameter int BOUNCE_COUNT  = 3,
    parameter int BOUNCE_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    quadrature_encoder_emulator_if.slave  bus
);

    localparam int DW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

    // Pending arithmetic is done two bits wider so that the sum of request and
    // start consumption can be range-checked before it is committed.
    localparam int EW = PENDING_W + 2;
    localparam logic signed [EW-1:0] P_MAX = EW'(2 ** (PENDING_W - 1) - 1);
    localparam logic signed [EW-1:0] P_MIN = -P_MAX;
    localparam logic signed [EW-1:0] P_ONE = EW'(1);

`ifdef QUAD_BOUNCE_EN
    localparam bit CFG_OK = (DWELL_CYCLES >= 2) && (BOUNCE_CYCLES >= 1) &&
                            (BOUNCE_COUNT >= 0) &&
                            (2 * BOUNCE_COUNT * BOUNCE_CYCLES < DWELL_CYCLES);
`else
    // Bounce parameters are accepted so both builds share one parameter list.
    localparam bit CFG_OK = (DWELL_CYCLES >= 2) && (BOUNCE_COUNT >= 0) &&
                            (BOUNCE_CYCLES >= 0);
`endif

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("quadrature_encoder_emulator: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PH1  = 3'd1,
        S_PH2  = 3'd2,
        S_PH3  = 3'd3,
        S_PH4  = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic [DW-1:0]                dwell_q, dwell_d;
    logic                         dir_ccw_q, dir_ccw_d;
    logic signed [PENDING_W-1:0]  pending_q, pending_d;
    logic                         overflow_q, overflow_d;
    logic                         busy_q, busy_d;
    logic                         enc_a_q, enc_a_d;
    logic                         enc_b_q, enc_b_d;

    logic                         start;
    logic signed [EW-1:0]         pend_ext, req, cons, sum_all, sum_cons;
    logic                         a_lvl, b_lvl;

`ifdef QUAD_BOUNCE_EN
    localparam int TW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES + 1) : 1;
    localparam int SW = $clog2(2 * BOUNCE_COUNT + 2);
    localparam logic [TW-1:0] TICK_LAST = TW'(BOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SEG_END   = SW'(2 * BOUNCE_COUNT);

    // tick counts cycles inside one bounce half-period; seg counts half-periods
    // since phase entry (even = new level, odd = old level).
    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] seg_q, seg_d;
    logic          bounce_flip;
    logic          changes_a;
`endif

    always_comb begin
        // ---------------- request queue ----------------
        pend_ext = {{2{pending_q[PENDING_W-1]}}, pending_q};
        start    = bus.enable && (state_q == S_IDLE) && (pending_q != '0);

        req = '0;
        if (bus.enable && bus.stepCW && !bus.stepCCW) begin
            req = P_ONE;
        end else if (bus.enable && bus.stepCCW && !bus.stepCW) begin
            req = -P_ONE;
        end

        // Starting a step moves pending one toward zero.
        cons = '0;
        if (start) begin
            cons = pending_q[PENDING_W-1] ? P_ONE : -P_ONE;
        end

        sum_all  = pend_ext + req + cons;
        sum_cons = pend_ext + cons;

        overflow_d = 1'b0;
        if ((sum_all > P_MAX) || (sum_all < P_MIN)) begin
            // Only the request is dropped; any start consumption still applies.
            pending_d  = sum_cons[PENDING_W-1:0];
            overflow_d = 1'b1;
        end else begin
            pending_d  = sum_all[PENDING_W-1:0];
        end

        // ---------------- phase sequencer ----------------
        state_d   = state_q;
        dwell_d   = dwell_q;
        dir_ccw_d = dir_ccw_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_PH1;
                    dwell_d   = DWELL_LOAD;
                    dir_ccw_d = pending_q[PENDING_W-1];
                end
            end
            S_PH1, S_PH2, S_PH3, S_PH4: begin
                if (dwell_q == '0) begin
                    dwell_d = DWELL_LOAD;
                    case (state_q)
                        S_PH1:   state_d = S_PH2;
                        S_PH2:   state_d = S_PH3;
                        S_PH3:   state_d = S_PH4;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Logical levels for the phase being entered. CW: 10,11,01,00;
        // CCW: 01,11,10,00. Rest (PH4 and IDLE) is 00.
        a_lvl = 1'b0;
        b_lvl = 1'b0;
        case (state_d)
            S_PH1: begin
                a_lvl = !dir_ccw_d;
                b_lvl = dir_ccw_d;
            end
            S_PH2: begin
                a_lvl = 1'b1;
                b_lvl = 1'b1;
            end
            S_PH3: begin
                a_lvl = dir_ccw_d;
                b_lvl = !dir_ccw_d;
            end
            default: begin
                a_lvl = 1'b0;
                b_lvl = 1'b0;
            end
        endcase

`ifdef QUAD_BOUNCE_EN
        tick_d = tick_q;
        seg_d  = seg_q;
        if (state_d != state_q) begin
            tick_d = '0;
            seg_d  = '0;
        end else if (seg_q < SEG_END) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                seg_d  = seg_q + 1'b1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        // Exactly one channel changes per phase; flip it back to its old level
        // during the odd bounce segments.
        bounce_flip = (state_d != S_IDLE) && (seg_d < SEG_END) && seg_d[0];
        changes_a   = ((state_d == S_PH1) || (state_d == S_PH3)) ^ dir_ccw_d;
        a_lvl       = a_lvl ^ (bounce_flip & changes_a);
        b_lvl       = b_lvl ^ (bounce_flip & !changes_a);
`endif

        enc_a_d = !a_lvl;
        enc_b_d = !b_lvl;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dwell_q    <= '0;
            dir_ccw_q  <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            enc_a_q    <= 1'b1;
            enc_b_q    <= 1'b1;
`ifdef QUAD_BOUNCE_EN
            tick_q     <= '0;
            seg_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            dir_ccw_q  <= dir_ccw_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            enc_a_q    <= enc_a_d;
            enc_b_q    <= enc_b_d;
`ifdef QUAD_BOUNCE_EN
            tick_q     <= tick_d;
            seg_q      <= seg_d;
`endif
        end
    end

    assign bus.encA     = enc_a_q;
    assign bus.encB     = enc_b_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;

endmodule

// File: doc/quadrature_encoder_emulator.md
Name: quadrature_encoder_emulator

Overview:
- Generates two-channel quadrature signals (encA/encB) that behave like the board's rotary encoder: active-low, idle high, one full 4-phase Gray cycle per detent step.
- Accepts clockwise/counter-clockwise step request strobes, queues them in a signed pending counter, and plays them out with a programmable phase dwell.
- Used as a stimulus source to close the loop on the rotary-encoder decoder and waveform FSM, in simulation or on hardware through a loopback pin pair.

Parameters:
- DWELL_CYCLES, 1000, clock cycles each quadrature phase is held; must be ≥2.
- PENDING_W, 4, width of the signed pending-step counter; magnitude saturates at 2^(PENDING_W-1)-1.
- BOUNCE_COUNT, 3, number of bounce pulses per edge (used only with QUAD_BOUNCE_EN).
- BOUNCE_CYCLES, 8, cycles per bounce half-period (used only with QUAD_BOUNCE_EN); requires 2*BOUNCE_COUNT*BOUNCE_CYCLES < DWELL_CYCLES.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  high: accept requests and start steps.
- stepCW  in  1  one-cycle strobe: queue one clockwise detent.
- stepCCW  in  1  one-cycle strobe: queue one counter-clockwise detent.
- encA  out  1  quadrature channel A, active-low (idle 1).
- encB  out  1  quadrature channel B, active-low (idle 1).
- busy  out  1  high while a step is being played (state ≠ IDLE).
- pending  out  PENDING_W  signed queued steps; positive = CW.
- overflow  out  1  one-cycle pulse when a request is dropped at saturation.

Behaviour:
- Reset (async, immediate): encA=encB=1, busy=0, pending=0, overflow=0, state=IDLE; a step in progress is abandoned.
- Internal logical levels (a,b); outputs are encA=~a and encB=~b, both registered. Rest = (a,b)=00.
- CW sequence: 10, 11, 01, 00. CCW sequence: 01, 11, 10, 00.
- States: IDLE, PH1, PH2, PH3, PH4. Each PHn is held exactly DWELL_CYCLES cycles, using a dwell counter reloaded on entry. PH4 (rest level) expiry → IDLE.
- IDLE → PH1 when enable=1 and pending≠0:
  - direction latched = sign(pending);
  - pending moves one toward zero in the same cycle.
- Request update each cycle, only when enable=1:
  - CW alone: pending+1.
  - CCW alone: pending−1.
  - Both together: no change (cancel).
  - Combined with a start consumption in the same cycle: net sum applied.
- Saturation: an update that would exceed +max or go below −max is dropped, and overflow pulses for 1 cycle.
- An opposite-direction request against a nonzero pending cancels one queued step. A step already started always completes in its latched direction.
- Latency: strobe sampled at edge k → pending updated at k → start at edge k+1 → first output edge visible after edge k+1 (2 cycles after the strobe cycle).
  - Subsequent edges follow every DWELL_CYCLES.
  - Step period is 4*DWELL_CYCLES+1 cycles; IDLE occupies 1 cycle between back-to-back steps.
- enable=0:
  - requests ignored;
  - an in-progress step runs to rest (never stops mid-detent);
  - no new step starts;
  - pending retained.
- busy is registered and equals (state≠IDLE).
- Only one channel changes per phase transition, so output is glitch-free Gray coded.

Optional Feature:
- Macro QUAD_BOUNCE_EN.
- Defined: on entry to each PHn, the channel that changes bounces before settling.
  - Pattern: new level for BOUNCE_CYCLES, then old level for BOUNCE_CYCLES, repeated BOUNCE_COUNT times, then new level stable for the rest of the phase.
  - The other channel stays stable; phase length is still DWELL_CYCLES.
  - A bounce counter is added. Reset clears it.
- Undefined: clean single edges, no bounce logic synthesized.

Test Plan:
- Bench parameters: DWELL_CYCLES=4, PENDING_W=4, unless stated otherwise.
- Reset: assert reset → encA=1, encB=1, busy=0, pending=0, overflow=0. Release and hold 20 cycles idle → outputs unchanged.
- Single CW: enable=1, stepCW at cycle 0 → (encA,encB) goes 01@2, 00@6, 10@10, 11@14; busy=1 for cycles 2..17, busy=0 at 18; pending 1@1, 0@2.
- Single CCW, then simultaneous requests: stepCCW at cycle 0 → (encA,encB) = 10, 00, 01, 11 at 4-cycle spacing. Later, stepCW=stepCCW=1 for one cycle → pending stays 0, busy stays 0.
- Saturation: 9 consecutive CW strobes at cycles 0..8 → first step starts at cycle 1; pending peaks at 7; overflow pulses once at cycle 8; exactly 8 full CW detent cycles emitted, then idle.
- Reset mid-step: assert reset during PH2 of a CW step with pending=3 → encA=encB=1 immediately, pending=0, no further edges after release.
- QUAD_BOUNCE_EN with DWELL_CYCLES=8, BOUNCE_COUNT=1, BOUNCE_CYCLES=1, single CW: encA reads 0,1,0,0,0,0,0,0 over PH1 while encB stays 1; the decoder still reports exactly one CW pulse.
